// File: rtl/timer_pkg.sv
// Shared definitions for the timing/counter subsystem (up-counter and down_timer).
package timer_pkg;

    // Default count width used by the counters unless overridden.
    localparam int TIMER_DEFAULT_WIDTH = 8;

    // Countdown timer control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // never loaded, or loaded with zero
        RUN     = 2'd1,  // counting down or holding with enable low
        EXPIRED = 2'd2   // reached zero without auto-reload
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/borrow_decrement.sv
// Combinational ripple-borrow decrementer: dec = val - 1, unsigned, WIDTH bits.
// Counterpart of the up-counter's ripple-carry incrementer.
module borrow_decrement #(
    parameter int WIDTH = timer_pkg::TIMER_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] dec
);

    // borrow[i] is the borrow flowing into bit i; subtracting one means bit 0
    // always sees a borrow. The borrow out of the top bit is not needed.
    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign dec[gi] = val[gi] ^ borrow[gi];
            if (gi < WIDTH - 1) begin : g_borrow
                assign borrow[gi+1] = ~val[gi] & borrow[gi];
            end
        end
    endgenerate

endmodule : borrow_decrement

// File: rtl/down_timer.sv
// Loadable countdown timer with terminal-count pulse and optional auto-reload.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    timer_state_t     state_reg,  state_next;
    logic [WIDTH-1:0] count_reg,  count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_reg,     tc_next;
    logic [WIDTH-1:0] count_dec;

    borrow_decrement #(
        .WIDTH (WIDTH)
    ) u_dec (
        .val (count_reg),
        .dec (count_dec)
    );

    // State, count, reload value and terminal pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
        end
    end

    // Next-state logic: load beats counting; only RUN with enable decrements.
    // The terminal tick is taken at count==1 so the counter never wraps from 0.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            state_next  = (load_val != '0) ? RUN : IDLE;
        end else if (state_reg == RUN && enable) begin
            if (count_reg == COUNT_ONE) begin
                tc_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload_reg;
                end else begin
                    count_next = '0;
                    state_next = EXPIRED;
                end
            end else begin
                count_next = count_dec;
            end
        end
    end

    assign count    = count_reg;
    assign zero     = (count_reg == '0);
    assign tc_pulse = tc_reg;
    assign busy     = (state_reg == RUN);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a behavioural reference model pushes the
// expected post-edge outputs into a queue as each cycle is driven; they are
// popped and compared one step after the clock edge.
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc_pulse;
    logic             busy;

    down_timer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .tc_pulse    (tc_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit zero;
        bit busy;
        bit tc;
    } exp_t;

    exp_t exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int tc_seen      = 0;

    // Reference model state: 0 = idle, 1 = running, 2 = expired.
    int m_count  = 0;
    int m_reload = 0;
    int m_mode   = 0;
    bit m_tc     = 0;

    task automatic check_val(input string tag, input int got, input int want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Apply one cycle of stimulus, predict its result, then compare after the edge.
    task automatic step(input bit rst, input bit ld, input int val, input bit en, input bit ar);
        exp_t e;
        reset       = rst;
        load        = ld;
        load_val    = WIDTH'(val);
        enable      = en;
        auto_reload = ar;

        if (rst) begin
            m_count = 0; m_reload = 0; m_mode = 0; m_tc = 0;
        end else if (ld) begin
            m_count  = val;
            m_reload = val;
            m_tc     = 0;
            m_mode   = (val != 0) ? 1 : 0;
        end else if (m_mode == 1 && en) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (ar) m_count = m_reload;
                else begin
                    m_count = 0;
                    m_mode  = 2;
                end
            end else begin
                m_count = m_count - 1;
                m_tc    = 0;
            end
        end else begin
            m_tc = 0;
        end
        e.count = m_count;
        e.zero  = (m_count == 0);
        e.busy  = (m_mode == 1);
        e.tc    = m_tc;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        if (tc_pulse) tc_seen++;
        $display("cyc %0d rst=%b ld=%b val=%0d en=%b ar=%b -> count=%0d zero=%b busy=%b tc=%b",
                 cyc, rst, ld, val, en, ar, count, zero, busy, tc_pulse);
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val("count", int'(count), e.count);
            check_val("zero", int'(zero), int'(e.zero));
            check_val("busy", int'(busy), int'(e.busy));
            check_val("tc_pulse", int'(tc_pulse), int'(e.tc));
        end
    endtask

    initial begin
        int tc_before;
        reset = 1'b1; load = 1'b0; load_val = '0; enable = 1'b0; auto_reload = 1'b0;

        // Reset for two cycles, then enable with no load: stays at 0.
        step(1, 0, 0, 0, 0);
        step(1, 1, 9, 1, 0);     // reset overrides load and enable
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Load 5, count to zero without reload, then hold at zero.
        tc_before = tc_seen;
        step(0, 1, 5, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        check_val("single_tc_load5", tc_seen - tc_before, 1);
        check_val("expired_hold", int'(count), 0);

        // Load 3 with auto-reload: periodic tick every 3 enabled cycles.
        tc_before = tc_seen;
        step(0, 1, 3, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 1);
        check_val("periodic_tc_count", tc_seen - tc_before, 3);
        check_val("periodic_busy", int'(busy), 1);

        // Load 4, enable pattern 1,0,0,1,1,1.
        tc_before = tc_seen;
        step(0, 1, 4, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check_val("gated_tc_count", tc_seen - tc_before, 1);

        // Load 0xFF, count down to 0x10, then reload 2 while enabled.
        step(0, 1, 255, 0, 0);
        for (int i = 0; i < 255 - 16; i++) step(0, 0, 0, 1, 0);
        check_val("reached_0x10", int'(count), 16);
        tc_before = tc_seen;
        step(0, 1, 2, 1, 0);
        check_val("load_wins", int'(count), 2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check_val("reload_mid_tc", tc_seen - tc_before, 1);

        // Reload value 1 with auto-reload: tick on every enabled cycle.
        tc_before = tc_seen;
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        check_val("reload1_tc_count", tc_seen - tc_before, 4);

        // Load 0 goes idle.
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Reset in the middle of a count at 7.
        step(0, 1, 10, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check_val("mid_count_7", int'(count), 7);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_down_timer

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable 8-bit (parameterizable) countdown timer; the decrementing counterpart of the team's free-running up-counter.
- Software/control logic loads a start value, enables counting, and receives a one-cycle terminal-count pulse when the count reaches zero.
- Optional auto-reload turns it into a periodic tick generator; it sits alongside the up-counter in the timing/counter subsystem.

Parameters:
WIDTH, 8, bit width of count, load value and reload register.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
load  input  1  capture load_val into count and reload register this cycle
load_val  input  WIDTH  start/reload value
enable  input  1  count-down qualifier; one decrement per cycle while high
auto_reload  input  1  on terminal count, reload from reload register instead of stopping
count  output  WIDTH  current count value (registered)
zero  output  1  high when count == 0 (registered-equivalent, no glitches)
tc_pulse  output  1  one-cycle pulse coincident with the terminal tick result
busy  output  1  high while state == RUN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous paths.
- Reset values: count=0, reload register=0, state=IDLE, zero=1, tc_pulse=0, busy=0. Reset overrides load/enable in the same cycle.
- States: IDLE (never loaded or loaded with 0), RUN (counting/holding), EXPIRED (reached 0, no reload).
- Priority per cycle: reset > load > enable.
- load=1: count<=load_val, reload<=load_val, tc_pulse<=0. Next state is RUN if load_val!=0, else IDLE. Accepted in any state, including mid-count; in-progress count is discarded with no tc_pulse.
- RUN, enable=0: count holds; tc_pulse=0.
- RUN, enable=1, count>1: count<=count-1; tc_pulse=0.
- RUN, enable=1, count==1 (terminal tick): tc_pulse<=1 for exactly one cycle.
  - auto_reload=1 (sampled this cycle): count<=reload, stay RUN. Period = reload value in enabled cycles.
  - auto_reload=0: count<=0, go EXPIRED.
- IDLE/EXPIRED: enable ignored; count held. No wrap from 0 to all-ones, ever.
- reload==1 with auto_reload=1: tc_pulse high on every enabled cycle, count stays 1.
- Latency: count reflects load on the cycle after load; tc_pulse asserts on the cycle after the terminal tick.
- Decrement arithmetic: ripple-borrow over WIDTH bits, unsigned.
- zero = (count==0), derived from the count register.
- busy = (state==RUN).

Decomposition:
- Shared package timer_pkg: state enum typedef (IDLE, RUN, EXPIRED) and a default-width constant shared with the up-counter.
- One natural sub-module: borrow_decrement (combinational, WIDTH-parameterized ripple-borrow decrementer, output val-1). Mirrors the increment logic of the up-counter; reusable by both.

Test Plan:
- Reset high 2 cycles, then low -> count=0, zero=1, busy=0, tc_pulse=0; enable=1 with no load -> count stays 0, no tc_pulse.
- load 5, enable=1 continuously, auto_reload=0 -> count 5,4,3,2,1,0; tc_pulse high only on the cycle count becomes 0; state EXPIRED; count stays 0 afterwards.
- load 3, auto_reload=1, enable=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1; tc_pulse on cycles 3, 6, 9; busy stays 1.
- load 4, enable toggles 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; tc_pulse once, at the final step.
- load 8'hFF and count to 8'h10, then load 2 with enable=1 in the same cycle -> count=2 next cycle (load wins), no tc_pulse; then 1, 0 with tc_pulse.
- load 0 -> state IDLE, zero=1, busy=0, no tc_pulse. Separately, assert reset mid-count at count=7 -> next cycle count=0, IDLE, tc_pulse=0.
